divider_9_3_6_bits: RTL
=======================

# divider_9_3_6_bits

- Sequential restoring divider: 9-bit dividend by 3-bit divisor.
- Produces a 6-bit quotient, a 3-bit remainder, an overflow flag and a divide-by-zero flag.
- Inverse of the team's 6×3→9 combinational multiplier. Used on the RNS datapath to recover operands and residues from 9-bit products.
- Valid/ready handshake on both sides. Processes one quotient bit per clock.

## Interface
- No parameters. Widths are fixed at 9/3/6/3.
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation (high only in IDLE)
- dividend  input  9  unsigned dividend
- divisor  input  3  unsigned divisor
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts the result
- quotient  output  6  low 6 bits of floor(dividend/divisor)
- remainder  output  3  dividend mod divisor
- overflow  output  1  full quotient > 63
- div_zero  output  1  divisor was 0 (driven only when RNS_DIV_ZERO_CHECK_EN is defined, else constant 0)

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch dividend into a 9-bit shift register and divisor into a 3-bit register, clear the 4-bit partial remainder, set count=8, go to CALC.
  - CALC: runs one restoring step per cycle, MSB first (step detailed below). When count==0, go to DONE; otherwise decrement count.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- One restoring step:
  - pr = {pr[2:0], dividend_msb}.
  - If pr ≥ {1'b0,divisor}, then pr -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - Shift the quotient bit into a 9-bit quotient register.
- Width rules:
  - pr is 4 bits. Its maximum before subtract is 2·7−1 = 13.
  - remainder = pr[2:0].
  - quotient = q9[5:0].
  - overflow = |q9[8:6].
- Results:
  - quotient, remainder, overflow and div_zero are registered.
  - They update only on entry to DONE and are held stable while out_valid=1.
- Divisor 0 without the check macro: every trial subtract succeeds. Result is q9=511, so quotient=63, overflow=1, remainder=0.
- No overlap: a new operation is accepted only after the result is accepted.
- Reset, asynchronous and at any time including mid-CALC:
  - state=IDLE, in_ready=1 after reset deasserts.
  - out_valid=0; quotient, remainder, overflow and div_zero = 0.
  - Internal registers are cleared. The operation in flight is discarded with no output.

## Timing
- Accept edge E0. CALC occupies edges E1..E9, 9 steps.
- out_valid rises after E9, giving 9 cycles of latency from the accept edge.
- out_valid falls on the edge where out_ready=1 is sampled. in_ready rises the same edge.
- A new in_valid is accepted no earlier than the following edge.
- Back-to-back throughput: one operation per 11 cycles when out_ready is held high.
- in_ready is combinational from state only. No combinational path exists from in_valid or out_ready to any output.
- out_ready asserted while out_valid=0 is ignored.

## Configuration
- RNS_DIV_ZERO_CHECK_EN defined:
  - At the accept edge, divisor==0 skips CALC and goes straight to DONE, so out_valid rises after E0.
  - Outputs in that case: div_zero=1, quotient=0, remainder=0, overflow=0.
  - Non-zero divisors behave as normal; div_zero=0 for them.
- RNS_DIV_ZERO_CHECK_EN undefined:
  - No check logic; div_zero is tied to 0.
  - Divisor 0 runs the full 9 cycles and yields quotient=63, remainder=0, overflow=1.

## Test plan
- 100/7 with out_ready held 1 -> out_valid exactly 9 cycles after accept; quotient=14, remainder=2, overflow=0.
- 378/6, then 0/5, back-to-back -> 63 r0 ovf=0, then 0 r0 ovf=0. Second accept occurs one edge after the first result is taken.
- 511/7 -> full quotient 73: quotient=9, remainder=0, overflow=1.
- 200/0 -> with macro: div_zero=1, quotient=0, remainder=0, out_valid 1 cycle after accept. Without macro: quotient=63, remainder=0, overflow=1 after 9 cycles.
- 255/3 with out_ready held 0 for 5 cycles after out_valid -> quotient=21, overflow=1, remainder=0 held stable. in_ready=0 and in_valid pulses are ignored until the handshake.
- rst_n pulsed low at CALC step 4 of 300/5 -> outputs 0 immediately and in_ready=1 after release. Next op 45/4 -> quotient=11, remainder=1 with no trace of the aborted op.

Source files
------------

// File: rtl/divider_9_3_6_bits.sv
// Sequential restoring divider, 9-bit dividend by 3-bit divisor, one quotient bit per clock.
// Optional macro RNS_DIV_ZERO_CHECK_EN: a zero divisor skips the iterations and flags div_zero.
module divider_9_3_6_bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] dividend,
    input  logic [2:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] quotient,
    output logic [2:0] remainder,
    output logic       overflow,
    output logic       div_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and the result fields hold steady until that edge, ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [8:0] dvd_sr;
    logic [2:0] dsr;
    logic [3:0] pr;
    logic [8:0] q9;
    logic [3:0] count;

    logic       accept;
    logic       zero_skip;
    logic       last_step;
    logic [3:0] pr_shift;
    logic [3:0] pr_step;
    logic       q_bit;
    logic [8:0] q9_step;

    assign accept    = in_valid && in_ready;
    assign last_step = (state == CALC) && (count == 4'd0);

`ifdef RNS_DIV_ZERO_CHECK_EN
    assign zero_skip = accept && (divisor == 3'd0);
`else
    assign zero_skip = 1'b0;
`endif

    // One restoring step; pr never exceeds 13 so 4 bits suffice.
    always_comb begin
        pr_shift = {pr[2:0], dvd_sr[8]};
        q_bit    = (pr_shift >= {1'b0, dsr});
        pr_step  = q_bit ? (pr_shift - {1'b0, dsr}) : pr_shift;
        q9_step  = {q9[7:0], q_bit};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = zero_skip ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic, decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sr <= '0;
            dsr    <= '0;
            pr     <= '0;
            q9     <= '0;
            count  <= '0;
        end else if (accept) begin
            dvd_sr <= dividend;
            dsr    <= divisor;
            pr     <= '0;
            q9     <= '0;
            count  <= 4'd8;
        end else if (state == CALC) begin
            dvd_sr <= {dvd_sr[7:0], 1'b0};
            pr     <= pr_step;
            q9     <= q9_step;
            if (count != 4'd0) begin
                count <= count - 4'd1;
            end
        end
    end

    // Result registers load only on entry to DONE.
    // A zero divisor leaves the shifted-in dividend bits in pr, so its remainder is forced to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else if (zero_skip) begin
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else if (last_step) begin
            quotient  <= q9_step[5:0];
            remainder <= (dsr == 3'd0) ? 3'd0 : pr_step[2:0];
            overflow  <= |q9_step[8:6];
        end
    end

`ifdef RNS_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero <= 1'b0;
        end else if (zero_skip) begin
            div_zero <= 1'b1;
        end else if (last_step) begin
            div_zero <= 1'b0;
        end
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule
